// File: rtl/foreground_capture_writer_pkg.sv
// Shared encodings for the foreground capture path. The scale codes are also
// decoded by the foreground scale stage, so both sides import them from here.
package foreground_capture_writer_pkg;

  localparam logic [1:0] SCALE_FULL    = 2'b11;
  localparam logic [1:0] SCALE_HALF    = 2'b10;
  localparam logic [1:0] SCALE_QUARTER = 2'b01;
  localparam logic [1:0] SCALE_OFF     = 2'b00;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } fg_state_e;

endpackage

// File: rtl/foreground_capture_writer_fifo.sv
// Write buffer between the address stage and the SRAM write port.
// Besides the head entry it exposes the entry behind the head, so the
// consumer can register the next head one cycle ahead of each pop.
module fg_write_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [WIDTH-1:0]       peek_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // Accept/release decisions; a push into a full buffer is legal when a pop
  // frees a slot in the same cycle.
  always_comb begin
    full_o    = (count_q == (PTR_W+1)'(DEPTH));
    empty_o   = (count_q == '0);
    do_pop    = pop_i && !empty_o;
    do_push   = push_i && (!full_o || do_pop);
    rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    head_o    = mem_q[rd_ptr_q];
    peek_o    = mem_q[rd_ptr_nx];
    count_o   = count_q;
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; reset discards whatever was queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_nx;
      end
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/foreground_capture_writer.sv
// Foreground framebuffer write side: decimates the incoming pixel stream to
// the pixels the scale stage can fetch, forms full-resolution word
// addresses, buffers them and issues one SRAM write per accepted request.
module foreground_capture_writer
  import foreground_capture_writer_pkg::*;
#(
  parameter int RESOLUTION_X = 800,
  parameter int RESOLUTION_Y = 600,
  parameter int PRECISION    = 10,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture_enable,
  input  logic [1:0]            ctrl_foreground_scale,
  input  logic                  in_valid,
  input  logic [PRECISION-1:0]  pixel_x,
  input  logic [PRECISION-1:0]  pixel_y,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic                  mem_write_req,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_ack,
  output logic                  capturing,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [PRECISION:0]    RES_X_EXT   = (PRECISION+1)'(RESOLUTION_X);
  localparam logic [PRECISION:0]    RES_Y_EXT   = (PRECISION+1)'(RESOLUTION_Y);
  localparam logic [PRECISION-1:0]  LAST_X      = PRECISION'(RESOLUTION_X - 1);
  localparam logic [PRECISION-1:0]  LAST_Y      = PRECISION'(RESOLUTION_Y - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(RESOLUTION_X);

  // Decimation rule: the scale stage only ever fetches these pixels.
  function automatic logic scale_keep(input logic [1:0] scale,
                                      input logic [1:0] x_lsb,
                                      input logic [1:0] y_lsb);
    case (scale)
      SCALE_FULL:    return 1'b1;
      SCALE_HALF:    return (x_lsb[0] == 1'b0) && (y_lsb[0] == 1'b0);
      SCALE_QUARTER: return (x_lsb == 2'b00) && (y_lsb == 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

  fg_state_e               state_q;
  fg_state_e               state_d;
  logic [1:0]              scale_lat_q;
  logic                    capturing_q;
  logic                    frame_done_q;

  logic                    scale_ok;
  logic                    frame_start;
  logic                    enter_cap;
  logic                    stay_cap;
  logic                    proc_p0;
  logic                    in_range_p0;
  logic                    keep_p0;
  logic                    last_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;

  logic                    vld_p1_q;
  logic                    last_p1_q;
  logic [ADDR_WIDTH-1:0]   addr_p1_q;
  logic [DATA_WIDTH-1:0]   data_p1_q;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        count_nx;
  logic [ENTRY_W-1:0]      fifo_head;
  logic [ENTRY_W-1:0]      fifo_peek;
  logic [ENTRY_W-1:0]      entry_p1;
  logic [ENTRY_W-1:0]      head_nx;
  logic                    drop_p1;

  logic                    req_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    overflow_q;

  // Stage 0: frame tracking, keep decision and address formation.
  // A pixel is only processed while the scale matches the one latched at
  // frame start, or on the (0,0) pixel that opens the frame.
  always_comb begin
    scale_ok    = capture_enable && (ctrl_foreground_scale != SCALE_OFF);
    frame_start = in_valid && (pixel_x == '0) && (pixel_y == '0);
    enter_cap   = (state_q == WAIT_FRAME) && scale_ok && frame_start;
    stay_cap    = (state_q == CAPTURE) && scale_ok &&
                  (ctrl_foreground_scale == scale_lat_q);
    proc_p0     = in_valid && (enter_cap || stay_cap);
    in_range_p0 = ({1'b0, pixel_x} < RES_X_EXT) && ({1'b0, pixel_y} < RES_Y_EXT);
    keep_p0     = proc_p0 && in_range_p0 &&
                  scale_keep(ctrl_foreground_scale, pixel_x[1:0], pixel_y[1:0]);
    last_p0     = proc_p0 && (pixel_x == LAST_X) && (pixel_y == LAST_Y);
    addr_p0     = ADDR_WIDTH'(pixel_y) * LINE_STRIDE + ADDR_WIDTH'(pixel_x);
  end

  // Next-state decode for the capture FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (scale_ok) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!scale_ok)        state_d = IDLE;
        else if (frame_start) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!scale_ok)                                  state_d = IDLE;
        else if (ctrl_foreground_scale != scale_lat_q)  state_d = WAIT_FRAME;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scale_lat_q  <= SCALE_OFF;
      capturing_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (enter_cap) begin
        scale_lat_q <= ctrl_foreground_scale;
      end
      capturing_q  <= (state_d == CAPTURE);
      frame_done_q <= last_p1_q;
    end
  end

  // Stage 1: control qualifiers for the entry about to be enqueued.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= keep_p0;
      last_p1_q <= last_p0;
    end
  end

  // Stage 1 payload; only meaningful when vld_p1_q is set.
  always_ff @(posedge clk) begin
    if (keep_p0) begin
      addr_p1_q <= addr_p0;
      data_p1_q <= in_pixel;
    end
  end

  fg_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (entry_p1),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .peek_o  (fifo_peek),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Stage 2: push/pop and lookahead of the head the write port shows next.
  // The presented request mirrors the FIFO head, so the entry stays queued
  // until acked and the registered copy is refreshed from the post-pop head.
  always_comb begin
    entry_p1  = {addr_p1_q, data_p1_q};
    fifo_pop  = req_q && mem_write_ack && !fifo_empty;
    fifo_push = vld_p1_q && (!fifo_full || fifo_pop);
    drop_p1   = vld_p1_q && fifo_full && !fifo_pop;
    count_nx  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    if (fifo_pop) begin
      head_nx = (fifo_count >= CNT_W'(2)) ? fifo_peek : entry_p1;
    end else begin
      head_nx = (fifo_count != '0) ? fifo_head : entry_p1;
    end
  end

  // Write-port registers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      req_q <= (count_nx != '0);
      if (count_nx != '0) begin
        addr_q <= head_nx[ENTRY_W-1:DATA_WIDTH];
        data_q <= head_nx[DATA_WIDTH-1:0];
      end
      if (drop_p1) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign mem_write_req  = req_q;
  assign mem_write_addr = addr_q;
  assign mem_write_data = data_q;
  assign capturing      = capturing_q;
  assign frame_done     = frame_done_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_foreground_capture_writer.sv
// Bench for foreground_capture_writer on a small 8x4 frame with a 4-entry
// write buffer. Stimulus queues expected SRAM writes; a monitor on the
// falling edge consumes them as the DUT issues accepted requests.
module tb_foreground_capture_writer;

  localparam int RX = 8;
  localparam int RY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_enable;
  logic [1:0]  ctrl_foreground_scale;
  logic        in_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] in_pixel;
  logic        mem_write_req;
  logic [18:0] mem_write_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_ack;
  logic        capturing;
  logic        frame_done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int fd_cnt   = 0;
  int w0;
  int f0;

  logic [34:0] exp_q[$];
  logic [34:0] got;
  logic [34:0] want;

  foreground_capture_writer #(
    .RESOLUTION_X (RX),
    .RESOLUTION_Y (RY),
    .PRECISION    (10),
    .ADDR_WIDTH   (19),
    .DATA_WIDTH   (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .capture_enable        (capture_enable),
    .ctrl_foreground_scale (ctrl_foreground_scale),
    .in_valid              (in_valid),
    .pixel_x               (pixel_x),
    .pixel_y               (pixel_y),
    .in_pixel              (in_pixel),
    .mem_write_req         (mem_write_req),
    .mem_write_addr        (mem_write_addr),
    .mem_write_data        (mem_write_data),
    .mem_write_ack         (mem_write_ack),
    .capturing             (capturing),
    .frame_done            (frame_done),
    .overflow              (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: score accepted writes, and check that a stalled request shows
  // the entry that is due next.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (!rst && mem_write_req) begin
      got = {mem_write_addr, mem_write_data};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required=no request",
                 mem_write_addr, mem_write_data);
      end else begin
        want = exp_q[0];
        if (got != want) begin
          failures++;
          $display("FAIL %s actual addr=%0d data=%h required addr=%0d data=%h",
                   mem_write_ack ? "write_value" : "stall_value",
                   got[34:16], got[15:0], want[34:16], want[15:0]);
        end
        if (mem_write_ack) begin
          void'(exp_q.pop_front());
        end
      end
      if (mem_write_ack) wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit exp_keep(input logic [1:0] s, input int x, input int y);
    if (x >= RX || y >= RY) return 1'b0;
    case (s)
      2'b11:   return 1'b1;
      2'b10:   return (x % 2 == 0) && (y % 2 == 0);
      2'b01:   return (x % 4 == 0) && (y % 4 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send(input int x, input int y, input logic [15:0] d, input bit keep);
    in_valid = 1'b1;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    in_pixel = d;
    if (keep) exp_q.push_back({19'(y * RX + x), d});
    tick();
  endtask

  // Linear pixel indices first..last of the frame; rule 00 expects no writes.
  task automatic send_range(input int first, input int last, input logic [1:0] rule,
                            input logic [15:0] base);
    for (int i = first; i <= last; i++) begin
      send(i % RX, i / RX, base + 16'(i), exp_keep(rule, i % RX, i / RX));
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    capture_enable = 1'b0;
    ctrl_foreground_scale = 2'b00;
    in_valid = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    in_pixel = '0;
    mem_write_ack = 1'b1;
    repeat (3) tick();
    check("rst_req", int'(mem_write_req), 0);
    check("rst_addr", int'(mem_write_addr), 0);
    check("rst_data", int'(mem_write_data), 0);
    check("rst_capturing", int'(capturing), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    tick();

    // Full scale: every pixel written at y*8+x, one frame_done.
    capture_enable = 1'b1;
    ctrl_foreground_scale = 2'b11;
    repeat (2) tick();
    w0 = wr_cnt; f0 = fd_cnt;
    send_range(0, 31, 2'b11, 16'hA000);
    in_valid = 1'b0;
    drain("drain_full");
    check("full_writes", wr_cnt - w0, 32);
    check("full_frame_done", fd_cnt - f0, 1);
    check("full_capturing", int'(capturing), 1);
    check("full_overflow", int'(overflow), 0);

    // Scale change 11->10 mid-frame: rest of frame dropped.
    w0 = wr_cnt; f0 = fd_cnt;
    send_range(0, 15, 2'b11, 16'hB000);
    ctrl_foreground_scale = 2'b10;
    send_range(16, 31, 2'b00, 16'hB000);
    in_valid = 1'b0;
    drain("drain_partial");
    check("partial_writes", wr_cnt - w0, 16);
    check("partial_frame_done", fd_cnt - f0, 0);
    check("partial_capturing", int'(capturing), 0);

    // Half scale frame: addr 0,2,4,6,16,18,20,22.
    w0 = wr_cnt; f0 = fd_cnt;
    send_range(0, 31, 2'b10, 16'hC000);
    in_valid = 1'b0;
    drain("drain_half");
    check("half_writes", wr_cnt - w0, 8);
    check("half_frame_done", fd_cnt - f0, 1);
    check("half_overflow", int'(overflow), 0);

    // Quarter scale frame (addr 0,4), then out-of-range coordinates.
    ctrl_foreground_scale = 2'b01;
    tick();
    w0 = wr_cnt; f0 = fd_cnt;
    send_range(0, 31, 2'b01, 16'hD000);
    send(8, 0, 16'hD0F0, 1'b0);
    send(0, 4, 16'hD0F1, 1'b0);
    in_valid = 1'b0;
    drain("drain_quarter");
    check("quarter_writes", wr_cnt - w0, 2);
    check("quarter_frame_done", fd_cnt - f0, 1);

    // Enable raised at pixel (2,1): nothing until the next (0,0).
    capture_enable = 1'b0;
    ctrl_foreground_scale = 2'b11;
    repeat (2) tick();
    check("off_capturing", int'(capturing), 0);
    capture_enable = 1'b1;
    w0 = wr_cnt;
    send_range(10, 31, 2'b00, 16'hE000);
    check("midstart_capturing", int'(capturing), 0);
    check("midstart_writes", wr_cnt - w0, 0);
    send(0, 0, 16'hE100, 1'b1);
    check("start_capturing", int'(capturing), 1);
    send_range(1, 31, 2'b11, 16'hE100);
    in_valid = 1'b0;
    drain("drain_midstart");
    check("midstart_frame_writes", wr_cnt - w0, 32);

    // Backpressure: 4 queued, the 5th kept pixel is dropped.
    mem_write_ack = 1'b0;
    w0 = wr_cnt;
    send_range(0, 3, 2'b11, 16'h1000);
    in_valid = 1'b0;
    repeat (3) tick();
    check("bp_overflow_before", int'(overflow), 0);
    check("bp_req", int'(mem_write_req), 1);
    send(4, 0, 16'h1004, 1'b0);
    in_valid = 1'b0;
    repeat (2) tick();
    check("bp_overflow_after", int'(overflow), 1);
    repeat (10) tick();
    mem_write_ack = 1'b1;
    drain("drain_bp");
    check("bp_writes", wr_cnt - w0, 4);
    check("bp_overflow_sticky", int'(overflow), 1);

    // Reset while a request is pending.
    mem_write_ack = 1'b0;
    send_range(8, 9, 2'b11, 16'h2000);
    in_valid = 1'b0;
    repeat (3) tick();
    check("prerst_req", int'(mem_write_req), 1);
    rst = 1'b1;
    tick();
    check("midrst_req", int'(mem_write_req), 0);
    exp_q.delete();
    mem_write_ack = 1'b1;
    tick();
    rst = 1'b0;
    w0 = wr_cnt;
    repeat (10) tick();
    check("postrst_writes", wr_cnt - w0, 0);
    check("postrst_req", int'(mem_write_req), 0);
    check("postrst_overflow", int'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
